// File: rtl/score_digits_driver.sv
// Purpose: converts a binary score to BCD (double dabble) and drives the digit-bitmap renderer from the pixel position.
// Latency: conversion SCORE_W clocks after capture, shown from the next startOfFrame; render outputs 1 clock after pixelX/pixelY.
// Backpressure: busy=1 during conversion and score_valid is dropped then; optional LEADING_ZERO_BLANK_EN blanks leading zeros.
module score_digits_driver #(
  parameter int DIGITS    = 4,
  parameter int SCORE_W   = 14,
  parameter int TOPLEFT_X = 16,
  parameter int TOPLEFT_Y = 8,
  parameter int DIGIT_W   = 16,
  parameter int DIGIT_H   = 32
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic [10:0]        pixelX,
  input  logic [10:0]        pixelY,
  input  logic               startOfFrame,
  input  logic [SCORE_W-1:0] score,
  input  logic               score_valid,
  output logic               busy,
  output logic               InsideRectangle,
  output logic [10:0]        offsetX,
  output logic [10:0]        offsetY,
  output logic [3:0]         digit
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(SCORE_W + 1);
  localparam int LOG2W = $clog2(DIGIT_W);
  localparam logic [31:0]        LIMIT   = 32'(10 ** DIGITS);
  localparam logic [SCORE_W-1:0] SAT_VAL = SCORE_W'(10 ** DIGITS - 1);
  localparam logic [CNT_W-1:0]   LAST    = CNT_W'(SCORE_W - 1);
  localparam logic [10:0] X0    = 11'(TOPLEFT_X);
  localparam logic [10:0] Y0    = 11'(TOPLEFT_Y);
  localparam logic [10:0] REG_W = 11'(DIGITS * DIGIT_W);
  localparam logic [10:0] REG_H = 11'(DIGIT_H);
  localparam logic [10:0] XMASK = 11'(DIGIT_W - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t             state, next_state;
  logic               capture, done;
  logic [SCORE_W-1:0] shift_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [BCD_W-1:0]   bcd_q, bcd_adj, bcd_next;
  logic [BCD_W-1:0]   pend_q, disp_q;

  // Add 3 to every nibble >= 5 so the following left shift carries correctly into the next decade.
  function automatic logic [BCD_W-1:0] add3(input logic [BCD_W-1:0] v);
    logic [BCD_W-1:0] r;
    r = v;
    for (int i = 0; i < DIGITS; i++) begin
      if (r[4*i +: 4] >= 4'd5) r[4*i +: 4] = r[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  assign bcd_adj  = add3(bcd_q);
  assign bcd_next = (bcd_adj << 1) | BCD_W'(shift_q[SCORE_W-1]);
  assign busy     = (state == SHIFT);

  // Conversion state register.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) state <= IDLE;
    else         state <= next_state;
  end

  // Next-state decode: accept a request only when idle, leave SHIFT after SCORE_W steps.
  always_comb begin
    next_state = state;
    capture    = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE:    if (score_valid) begin capture = 1'b1; next_state = SHIFT; end
      SHIFT:   if (cnt_q == LAST) begin done = 1'b1; next_state = IDLE; end
      default: next_state = IDLE;
    endcase
  end

  // Double-dabble datapath; the finished BCD lands in the pending register on the last step.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      shift_q <= '0;
      cnt_q   <= '0;
      bcd_q   <= '0;
      pend_q  <= '0;
    end else if (capture) begin
      shift_q <= (32'(score) >= LIMIT) ? SAT_VAL : score;
      cnt_q   <= '0;
      bcd_q   <= '0;
    end else if (busy) begin
      shift_q <= shift_q << 1;
      cnt_q   <= cnt_q + 1'b1;
      bcd_q   <= bcd_next;
      if (done) pend_q <= bcd_next;
    end
  end

  // Frame-aligned copy; a same-cycle pending write is seen only at the following frame.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN)           disp_q <= '0;
    else if (startOfFrame) disp_q <= pend_q;
  end

  logic [10:0]       rel_x, rel_y, idx;
  logic              in_region, show, seen;
  logic [DIGITS-1:0] shown;
  logic [3:0]        sel_nib;

  assign rel_x     = pixelX - X0;
  assign rel_y     = pixelY - Y0;
  assign idx       = rel_x >> LOG2W;
  assign in_region = (pixelX >= X0) && (rel_x < REG_W) && (pixelY >= Y0) && (rel_y < REG_H);

  // Per-cell visibility mask, derived from the displayed value only.
  always_comb begin
    shown = '1;
    seen  = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
    for (int i = 0; i < DIGITS; i++) begin
      seen     = seen | (disp_q[4*(DIGITS-1-i) +: 4] != 4'd0);
      shown[i] = seen | (i == DIGITS - 1);
    end
`endif
  end

  // Select the nibble and visibility of the cell under the pixel; cell 0 is the MSD.
  always_comb begin
    sel_nib = 4'd0;
    show    = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx == 11'(i)) begin
        sel_nib = disp_q[4*(DIGITS-1-i) +: 4];
        show    = shown[i];
      end
    end
  end

  // Registered render outputs, forced to zero outside a visible cell.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      InsideRectangle <= 1'b0;
      offsetX         <= '0;
      offsetY         <= '0;
      digit           <= '0;
    end else if (in_region && show) begin
      InsideRectangle <= 1'b1;
      offsetX         <= rel_x & XMASK;
      offsetY         <= rel_y;
      digit           <= sel_nib;
    end else begin
      InsideRectangle <= 1'b0;
      offsetX         <= '0;
      offsetY         <= '0;
      digit           <= '0;
    end
  end

endmodule

// File: tb/tb_score_digits_driver.sv
// Bench for score_digits_driver: directed scenarios plus random scores/pixels against an arithmetic model.
module tb_score_digits_driver;

  localparam int DIGITS = 4, SCORE_W = 14, TX = 16, TY = 8, DW = 16, DH = 32;

  logic               clk = 1'b0;
  logic               resetN;
  logic [10:0]        pixelX, pixelY;
  logic               startOfFrame;
  logic [SCORE_W-1:0] score;
  logic               score_valid;
  logic               busy, InsideRectangle;
  logic [10:0]        offsetX, offsetY;
  logic [3:0]         digit;

  int n_checks = 0;
  int n_errors = 0;
  int m_pend   = 0;
  int m_disp   = 0;

  score_digits_driver dut (
    .clk(clk), .resetN(resetN), .pixelX(pixelX), .pixelY(pixelY),
    .startOfFrame(startOfFrame), .score(score), .score_valid(score_valid),
    .busy(busy), .InsideRectangle(InsideRectangle),
    .offsetX(offsetX), .offsetY(offsetY), .digit(digit)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int sat(input int v);
    return (v >= 10 ** DIGITS) ? 10 ** DIGITS - 1 : v;
  endfunction

  // Model: decimal digit of the displayed value under (x,y), from plain arithmetic.
  task automatic probe(input int x, input int y);
    int ins, idx, p, ex_ox, ex_oy, ex_dg;
    pixelX = 11'(x);
    pixelY = 11'(y);
    step();
    ins = (x >= TX && x < TX + DIGITS * DW && y >= TY && y < TY + DH) ? 1 : 0;
    ex_ox = 0; ex_oy = 0; ex_dg = 0;
    if (ins == 1) begin
      idx   = (x - TX) / DW;
      p     = 10 ** (DIGITS - 1 - idx);
      ex_ox = (x - TX) % DW;
      ex_oy = y - TY;
      ex_dg = (m_disp / p) % 10;
`ifdef LEADING_ZERO_BLANK_EN
      if (m_disp < p && idx != DIGITS - 1) begin
        ins = 0; ex_ox = 0; ex_oy = 0; ex_dg = 0;
      end
`endif
    end
    check($sformatf("ins(%0d,%0d)", x, y), 32'(InsideRectangle), 32'(ins));
    check($sformatf("offx(%0d,%0d)", x, y), 32'(offsetX), 32'(ex_ox));
    check($sformatf("offy(%0d,%0d)", x, y), 32'(offsetY), 32'(ex_oy));
    check($sformatf("digit(%0d,%0d)", x, y), 32'(digit), 32'(ex_dg));
  endtask

  task automatic probe_cells();
    for (int i = 0; i < DIGITS; i++) probe(TX + DW * i + 7, TY + 13);
  endtask

  task automatic frame();
    startOfFrame = 1'b1;
    step();
    startOfFrame = 1'b0;
    m_disp = m_pend;
  endtask

  task automatic wait_idle(output int cnt);
    cnt = 0;
    while (busy === 1'b1 && cnt < 200) begin
      step();
      cnt++;
    end
  endtask

  task automatic load(input int v);
    int cnt;
    score       = SCORE_W'(v);
    score_valid = 1'b1;
    step();
    score_valid = 1'b0;
    wait_idle(cnt);
    check("busy_len", 32'(cnt), 32'(SCORE_W));
    m_pend = sat(v);
  endtask

  // Request in cycle 0; startOfFrame lands on the last SHIFT cycle, i.e. with the pending write.
  task automatic load_coincident(input int v);
    score       = SCORE_W'(v);
    score_valid = 1'b1;
    step();
    score_valid = 1'b0;
    repeat (SCORE_W - 1) step();
    check("busy_last_cycle", 32'(busy), 32'd1);
    startOfFrame = 1'b1;
    step();
    startOfFrame = 1'b0;
    m_disp = m_pend;
    m_pend = sat(v);
    check("busy_after_coincident", 32'(busy), 32'd0);
  endtask

  initial begin
    int cnt;
    resetN = 1'b0; pixelX = '0; pixelY = '0; startOfFrame = 1'b0;
    score = '0; score_valid = 1'b0;
    repeat (3) step();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ins", 32'(InsideRectangle), 32'd0);
    check("rst_offx", 32'(offsetX), 32'd0);
    check("rst_offy", 32'(offsetY), 32'd0);
    check("rst_digit", 32'(digit), 32'd0);
    resetN = 1'b1;
    step();

    // Basic conversion, then the reference pixel (37,11).
    load(1234);
    frame();
    probe(37, 11);
    probe_cells();

    // Tear-free update: new value held back until startOfFrame.
    load(5678);
    probe(37, 11);
    frame();
    probe(37, 11);
    load_coincident(4321);
    probe_cells();
    frame();
    probe_cells();

    // Request during busy is dropped.
    score = SCORE_W'(100); score_valid = 1'b1;
    step();
    score_valid = 1'b0;
    step();
    score = SCORE_W'(200); score_valid = 1'b1;
    step();
    score_valid = 1'b0;
    wait_idle(cnt);
    check("busy_drop_idle", 32'(cnt < 200), 32'd1);
    m_pend = 100;
    frame();
    probe_cells();

    // Saturation and region boundaries.
    load(12000);
    frame();
    probe_cells();
    probe(15, 8); probe(16, 8); probe(79, 39); probe(80, 39); probe(16, 40);

    // Small value: leading cells are zero (blanked when that option is built in).
    load(7);
    frame();
    probe_cells();

    // Reset in the middle of a conversion.
    load(9876);
    frame();
    score = SCORE_W'(4444); score_valid = 1'b1;
    step();
    score_valid = 1'b0;
    repeat (3) step();
    resetN = 1'b0;
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_ins", 32'(InsideRectangle), 32'd0);
    m_pend = 0; m_disp = 0;
    step();
    resetN = 1'b1;
    step();
    check("post_rst_busy", 32'(busy), 32'd0);
    frame();
    probe_cells();

    // Random scores and pixels.
    for (int it = 0; it < 25; it++) begin
      load(int'($urandom_range(0, 16383)));
      if ($urandom_range(0, 3) != 0) frame();
      for (int k = 0; k < 3; k++)
        probe(int'($urandom_range(0, 99)), int'($urandom_range(0, 49)));
      probe(TX + int'($urandom_range(0, DIGITS * DW - 1)), TY + int'($urandom_range(0, DH - 1)));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/score_digits_driver.md
Name: score_digits_driver

Overview:
- Drives the digit-bitmap renderer's inputs (InsideRectangle, offsetX, offsetY, digit) from a binary score and the current VGA pixel coordinate.
- Converts the score to BCD sequentially using shift-add-3 (double dabble), one bit per clock.
- Displays a new value only from the next startOfFrame, so the screen never shows a half-updated number.
- Sits between game logic (score source) and the per-digit bitmap drawer in the VGA path.

Parameters:
- DIGITS, 4, number of decimal digits shown, MSD leftmost.
- SCORE_W, 14, width of the binary score input.
- TOPLEFT_X, 16, left edge of digit 0 in pixels.
- TOPLEFT_Y, 8, top edge of the digit row in pixels.
- DIGIT_W, 16, digit cell width; must be a power of two.
- DIGIT_H, 32, digit cell height.

Ports:
- clk  in  1  system clock.
- resetN  in  1  asynchronous active-low reset.
- pixelX  in  11  current pixel column.
- pixelY  in  11  current pixel row.
- startOfFrame  in  1  one-cycle pulse at frame start.
- score  in  SCORE_W  binary score; sampled when score_valid=1.
- score_valid  in  1  request to convert score.
- busy  out  1  conversion in progress; score_valid is ignored while high.
- InsideRectangle  out  1  pixel lies inside a shown digit cell.
- offsetX  out  11  column within the digit cell.
- offsetY  out  11  row within the digit cell.
- digit  out  4  BCD value of the digit under the pixel.

Behaviour:
- Clock and reset: one clock (clk). resetN is asynchronous and active-low.
- Reset values:
  - busy=0, InsideRectangle=0, offsetX=0, offsetY=0, digit=0.
  - FSM=IDLE; pending BCD register=0; display BCD register=0.
- Conversion FSM:
  - IDLE: score_valid=1 in cycle 0 captures score. If score >= 10^DIGITS, saturate the capture to 10^DIGITS-1. Clear the BCD accumulator and go to SHIFT.
  - SHIFT: each cycle, add 3 to every BCD nibble >=5, then shift left one bit, bringing in the score MSB. Runs exactly SCORE_W cycles (cycles 1..SCORE_W), with busy=1 throughout.
  - End of cycle SCORE_W: write the result to the pending register and return to IDLE. busy=0 from cycle SCORE_W+1.
  - score_valid while busy: dropped, with no queueing.
  - score_valid in the same cycle busy falls: busy is already 0 that cycle, so the request is accepted.
- Frame synchronisation:
  - startOfFrame=1 copies pending to display, using register-read semantics.
  - If a pending write and startOfFrame occur in the same cycle, display receives the old pending value. The new value appears at the following frame.
- Rendering (all outputs registered, latency 1 clock from pixelX/pixelY):
  - relX = pixelX - TOPLEFT_X; relY = pixelY - TOPLEFT_Y.
  - Inside when pixelX >= TOPLEFT_X, relX < DIGITS*DIGIT_W, pixelY >= TOPLEFT_Y and relY < DIGIT_H. Comparisons are unsigned with no wrap; pixels left of or above the origin are outside.
  - Digit index = relX >> log2(DIGIT_W); index 0 is the MSD.
  - offsetX = relX & (DIGIT_W-1); offsetY = relY; digit = display nibble[DIGITS-1-index].
  - Outside the region: InsideRectangle=0, offsetX=0, offsetY=0, digit=0.
- Downstream latency: the bitmap drawer adds its own register stage. Total pixel-to-drawingRequest latency is 2 clocks, and the mux must align for this.
- Reset mid-conversion: conversion aborts, busy=0, display=0. The next frame shows all zeros.

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN.
- Defined:
  - Digits left of the most significant nonzero digit force InsideRectangle=0 (offsets and digit are also 0).
  - The least significant digit is always shown, so score 0 displays "0".
  - The blank mask is computed from the display register only.
- Undefined: all DIGITS cells are shown, including leading zeros.

Test Plan:
- Basic conversion: score=1234, score_valid pulse. Then:
  - busy high for exactly 14 cycles.
  - After the next startOfFrame, pixel (TOPLEFT_X+21, TOPLEFT_Y+3), i.e. (37,11), gives one cycle later: InsideRectangle=1, digit=2, offsetX=5, offsetY=3.
- Saturation: score=12000 -> every digit cell reads 9.
- Tear-free update:
  - display shows 1234.
  - Load 5678 and let the conversion finish with no startOfFrame: pixels still read 1234.
  - After startOfFrame: pixels read 5678.
  - Pending write coincident with startOfFrame: still the old value until the next frame.
- Busy drop: load 100, then score_valid with 200 two cycles later -> display ends as 100, not 200.
- Region boundaries: with defaults, check (15,8), (16,8), (79,39), (80,39) and (16,40):
  - (16,8) and (79,39) are inside; (79,39) reads digit index 3, offsetX=15, offsetY=31.
  - (15,8), (80,39) and (16,40) give all outputs 0.
- Reset and leading zeros:
  - Assert resetN=0 mid-SHIFT -> busy=0 immediately, digits read 0.
  - With LEADING_ZERO_BLANK_EN, score=7 -> cells 0-2 InsideRectangle=0, cell 3 digit=7.
